// File: rtl/param_address_register_file_if.sv
// Bus bundle for the address register file: control/select inputs, read ports and stack status.
// The master drives the controls; the register file is the slave.
interface param_address_register_file_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
);
  logic [WIDTH-1:0]    i;
  logic [NUM_REGS-1:0] reg_sel;     // active-low per-register enable
  logic [2:0]          fun_sel;
  logic                pc_inc;
  logic                push;
  logic                pop;
  logic                err_clr;
  logic [SEL_W-1:0]    out_c_sel;
  logic [SEL_W-1:0]    out_d_sel;
  logic [WIDTH-1:0]    out_c;
  logic [WIDTH-1:0]    out_d;
  logic                stack_full;
  logic                stack_empty;
  logic                stack_ovf;
  logic                stack_unf;

  modport master (
    output i, reg_sel, fun_sel, pc_inc, push, pop, err_clr, out_c_sel, out_d_sel,
    input  out_c, out_d, stack_full, stack_empty, stack_ovf, stack_unf
  );

  modport slave (
    input  i, reg_sel, fun_sel, pc_inc, push, pop, err_clr, out_c_sel, out_d_sel,
    output out_c, out_d, stack_full, stack_empty, stack_ovf, stack_unf
  );
endinterface

// File: rtl/param_address_register_file.sv
// Address register file: PC (idx 0), AR (idx 1), SP (idx 2) and extra address registers,
// each with hold/inc/dec/load/clear, a PC fetch strobe and a bounds-checked down-growing stack.
module param_address_register_file #(
  parameter int             WIDTH    = 16,
  parameter int             NUM_REGS = 4,
  parameter int             SEL_W    = 2,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter logic [WIDTH-1:0] SP_TOP   = WIDTH'('h00FF),
  parameter logic [WIDTH-1:0] SP_LIMIT = WIDTH'('h00E0)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  param_address_register_file_if.slave bus
);

  localparam int               IDX_PC   = 0;
  localparam int               IDX_SP   = 2;
  localparam int               RD_DEPTH = 1 << SEL_W;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [2:0] {
    FS_HOLD  = 3'b000,
    FS_INC   = 3'b001,
    FS_DEC   = 3'b010,
    FS_LOAD  = 3'b011,
    FS_CLEAR = 3'b100
  } fun_sel_e;

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] rd_tbl [RD_DEPTH];
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_set, unf_set;
  logic             op_active;
  logic             sp_full, sp_empty;
  fun_sel_e         fs;

  // Codes 101-111 fall through to the default and behave as hold.
  function automatic logic [WIDTH-1:0] apply_fun(
    input logic [WIDTH-1:0] cur,
    input fun_sel_e         op,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] res;
    case (op)
      FS_INC:   res = cur + ONE;
      FS_DEC:   res = cur - ONE;
      FS_LOAD:  res = din;
      FS_CLEAR: res = '0;
      default:  res = cur;
    endcase
    return res;
  endfunction

  assign fs        = fun_sel_e'(bus.fun_sel);
  assign op_active = (fs == FS_INC) || (fs == FS_DEC) || (fs == FS_LOAD) || (fs == FS_CLEAR);
  assign sp_full   = (regs_q[IDX_SP] == SP_LIMIT);
  assign sp_empty  = (regs_q[IDX_SP] == SP_TOP);

  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves a latch.
    regs_d  = regs_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    // An explicit FunSel on PC beats the fetch strobe.
    if (!bus.reg_sel[IDX_PC] && op_active) begin
      regs_d[IDX_PC] = apply_fun(regs_q[IDX_PC], fs, bus.i);
    end else if (bus.pc_inc) begin
      regs_d[IDX_PC] = regs_q[IDX_PC] + ONE;
    end

    // Stack ops beat FunSel; simultaneous push and pop cancel with no flag change.
    if (bus.push && !bus.pop) begin
      if (sp_full) ovf_set = 1'b1;
      else         regs_d[IDX_SP] = regs_q[IDX_SP] - ONE;
    end else if (bus.pop && !bus.push) begin
      if (sp_empty) unf_set = 1'b1;
      else          regs_d[IDX_SP] = regs_q[IDX_SP] + ONE;
    end else if (!bus.push && !bus.reg_sel[IDX_SP]) begin
      regs_d[IDX_SP] = apply_fun(regs_q[IDX_SP], fs, bus.i);
    end

    for (int k = 1; k < NUM_REGS; k++) begin
      if (k != IDX_SP && !bus.reg_sel[k]) begin
        regs_d[k] = apply_fun(regs_q[k], fs, bus.i);
      end
    end

    ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
    unf_d = unf_set | (unf_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register array is reset element by element; it is flops, not a RAM macro.
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
      regs_q[IDX_PC] <= PC_RESET;
      regs_q[IDX_SP] <= SP_TOP;
      ovf_q          <= 1'b0;
      unf_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge state.
      regs_q <= regs_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Read table padded to the full select range; unused indices read as zero.
  for (genvar k = 0; k < RD_DEPTH; k++) begin : g_rd
    if (k < NUM_REGS) begin : g_reg
      assign rd_tbl[k] = regs_q[k];
    end else begin : g_zero
      assign rd_tbl[k] = '0;
    end
  end

  assign bus.out_c       = rd_tbl[bus.out_c_sel];
  assign bus.out_d       = rd_tbl[bus.out_d_sel];
  assign bus.stack_full  = sp_full;
  assign bus.stack_empty = sp_empty;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;

endmodule
